// File: rtl/game2048_pkg.sv
// Shared types and LFSR helper for the 2048 game core.
package game2048_pkg;

  typedef enum logic [1:0] {
    DirLeft  = 2'd0,
    DirRight = 2'd1,
    DirUp    = 2'd2,
    DirDown  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StReady,
    StSlide,
    StSpawn,
    StCheck,
    StWin,
    StLose
  } state_t;

  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_next(logic [15:0] cur);
    return {cur[14:0], ^(cur & LfsrTaps)};
  endfunction

endpackage

// File: rtl/game2048_line_merge.sv
// Combinational compress-and-merge of one board line toward index 0,
// each tile merging at most once.
module game2048_line_merge #(
  parameter int unsigned N       = 4,
  parameter int unsigned EXP_W   = 4,
  parameter int unsigned SCORE_W = 20
) (
  input  logic [N-1:0][EXP_W-1:0] line_in,
  output logic [N-1:0][EXP_W-1:0] line_out,
  output logic                    changed,
  output logic [SCORE_W-1:0]      score_inc
);

  // One spare zero slot so the pair lookahead never runs off the end.
  logic [N:0][EXP_W-1:0] compact;
  logic [SCORE_W:0]      sum;
  logic [SCORE_W-1:0]    term;
  int unsigned           fill;
  int unsigned           pos;
  logic                  skip;

  always_comb begin
    compact   = '0;
    line_out  = '0;
    score_inc = '0;
    sum       = '0;
    term      = '0;
    fill      = 0;
    pos       = 0;
    skip      = 1'b0;

    for (int unsigned i = 0; i < N; i++) begin
      if (line_in[i] != '0) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (k == fill) compact[k] = line_in[i];
        end
        fill++;
      end
    end

    for (int unsigned i = 0; i < N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (compact[i] != '0) begin
        if (compact[i+1] == compact[i]) begin
          for (int unsigned k = 0; k < N; k++) begin
            if (k == pos) line_out[k] = compact[i] + 1'b1;
          end
          term = (32'(compact[i]) + 32'd1 < SCORE_W) ?
                 (SCORE_W'(1) << (32'(compact[i]) + 32'd1)) : '1;
          sum       = {1'b0, score_inc} + {1'b0, term};
          score_inc = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
          skip      = 1'b1;
        end else begin
          for (int unsigned k = 0; k < N; k++) begin
            if (k == pos) line_out[k] = compact[i];
          end
        end
        pos++;
      end
    end
  end

  assign changed = (line_out != line_in);

endmodule

// File: rtl/game2048_engine.sv
// 2048 game core: board state, line-per-cycle slide, LFSR tile spawn and
// win/lose detection.
module game2048_engine
  import game2048_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned EXP_W     = 4,
  parameter int unsigned WIN_EXP   = 11,
  parameter int unsigned SCORE_W   = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   move_valid,
  input  logic [1:0]             move_dir,
  output logic                   move_ready,
  output logic [N*N*EXP_W-1:0]   grid,
  output logic [SCORE_W-1:0]     score,
  output logic                   win,
  output logic                   lose,
  output logic                   busy
);

  localparam int unsigned NN    = N * N;
  localparam int unsigned IdxW  = $clog2(NN);
  localparam int unsigned LineW = $clog2(N);

  state_t                    state_q, state_d;
  dir_t                      dir_q, dir_d;
  logic [NN-1:0][EXP_W-1:0]  board_q, board_d;
  logic [SCORE_W-1:0]        score_q, score_d;
  logic                      win_q, win_d, lose_q, lose_d;
  logic [15:0]               lfsr_q;
  logic [LineW-1:0]          line_q, line_d;
  logic                      changed_q, changed_d;
  logic [IdxW-1:0]           spawn_pos_q, spawn_pos_d;
  logic                      spawn_first_q, spawn_first_d;
  logic                      spawn_more_q, spawn_more_d;
  logic                      init_seq_q, init_seq_d;

  logic [N-1:0][EXP_W-1:0]   line_in, merged;
  logic                      line_changed;
  logic [SCORE_W-1:0]        line_inc;
  logic [SCORE_W:0]          score_sum;
  logic [IdxW-1:0]           spawn_idx;
  logic                      any_win, any_empty, any_pair;

  // Board cell holding position k of the current line, read toward the move.
  function automatic int unsigned cell_of(dir_t d, int unsigned line, int unsigned k);
    case (d)
      DirLeft:  return line * N + k;
      DirRight: return line * N + (N - 1 - k);
      DirUp:    return k * N + line;
      default:  return (N - 1 - k) * N + line;
    endcase
  endfunction

  always_comb begin
    line_in = '0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned c = 0; c < NN; c++) begin
        if (c == cell_of(dir_q, 32'(line_q), k)) line_in[k] = board_q[c];
      end
    end
  end

  game2048_line_merge #(
    .N       (N),
    .EXP_W   (EXP_W),
    .SCORE_W (SCORE_W)
  ) u_line_merge (
    .line_in   (line_in),
    .line_out  (merged),
    .changed   (line_changed),
    .score_inc (line_inc)
  );

  assign score_sum = {1'b0, score_q} + {1'b0, line_inc};
  assign spawn_idx = spawn_first_q ? IdxW'(lfsr_q % 16'(NN)) : spawn_pos_q;

  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int unsigned c = 0; c < NN; c++) begin
      if (board_q[c] >= EXP_W'(WIN_EXP)) any_win = 1'b1;
      if (board_q[c] == '0) any_empty = 1'b1;
    end
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c + 1 < N; c++) begin
        if (board_q[r*N+c] == board_q[r*N+c+1]) any_pair = 1'b1;
        if (board_q[c*N+r] == board_q[(c+1)*N+r]) any_pair = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    board_d       = board_q;
    score_d       = score_q;
    win_d         = win_q;
    lose_d        = lose_q;
    line_d        = line_q;
    changed_d     = changed_q;
    spawn_pos_d   = spawn_pos_q;
    spawn_first_d = spawn_first_q;
    spawn_more_d  = spawn_more_q;
    init_seq_d    = init_seq_q;

    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (start) state_d = StInit;
      end
      StReady: begin
        if (start) begin
          state_d = StInit;
        end else if (move_valid) begin
          state_d   = StSlide;
          dir_d     = dir_t'(move_dir);
          line_d    = '0;
          changed_d = 1'b0;
        end
      end
      StInit: begin
        board_d       = '0;
        score_d       = '0;
        win_d         = 1'b0;
        lose_d        = 1'b0;
        state_d       = StSpawn;
        spawn_first_d = 1'b1;
        spawn_more_d  = 1'b1;
        init_seq_d    = 1'b1;
      end
      StSlide: begin
        for (int unsigned k = 0; k < N; k++) begin
          for (int unsigned c = 0; c < NN; c++) begin
            if (c == cell_of(dir_q, 32'(line_q), k)) board_d[c] = merged[k];
          end
        end
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        changed_d = changed_q | line_changed;
        line_d    = line_q + 1'b1;
        if (line_q == LineW'(N - 1)) begin
          if (changed_d) begin
            state_d       = StSpawn;
            spawn_first_d = 1'b1;
            spawn_more_d  = 1'b0;
            init_seq_d    = 1'b0;
          end else begin
            // Unchanged board re-checks to the same verdict, so this lands in ready.
            state_d = StCheck;
          end
        end
      end
      StSpawn: begin
        spawn_first_d = 1'b0;
        spawn_pos_d   = (spawn_idx == IdxW'(NN - 1)) ? '0 : spawn_idx + 1'b1;
        if (board_q[spawn_idx] == '0) begin
          board_d[spawn_idx] = (lfsr_q[3:0] == 4'd0) ? EXP_W'(2) : EXP_W'(1);
          if (spawn_more_q) begin
            spawn_more_d  = 1'b0;
            spawn_first_d = 1'b1;
          end else begin
            state_d = init_seq_q ? StReady : StCheck;
          end
        end
      end
      StCheck: begin
        if (any_win) begin
          win_d   = 1'b1;
          state_d = StWin;
        end else if (!any_empty && !any_pair) begin
          lose_d  = 1'b1;
          state_d = StLose;
        end else begin
          state_d = StReady;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      dir_q         <= DirLeft;
      board_q       <= '0;
      score_q       <= '0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      lfsr_q        <= LFSR_SEED;
      line_q        <= '0;
      changed_q     <= 1'b0;
      spawn_pos_q   <= '0;
      spawn_first_q <= 1'b0;
      spawn_more_q  <= 1'b0;
      init_seq_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      board_q       <= board_d;
      score_q       <= score_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      lfsr_q        <= lfsr_next(lfsr_q);
      line_q        <= line_d;
      changed_q     <= changed_d;
      spawn_pos_q   <= spawn_pos_d;
      spawn_first_q <= spawn_first_d;
      spawn_more_q  <= spawn_more_d;
      init_seq_q    <= init_seq_d;
    end
  end

  assign grid       = board_q;
  assign score      = score_q;
  assign win        = win_q;
  assign lose       = lose_q;
  assign move_ready = (state_q == StReady);
  assign busy       = (state_q == StSlide) || (state_q == StSpawn) ||
                      (state_q == StCheck) || (state_q == StInit);

endmodule

// File: tb/tb_game2048_engine.sv
// Random-play bench for game2048_engine against a board-level game model.
module tb_game2048_engine;

  localparam int unsigned N        = 3;
  localparam int unsigned NN       = N * N;
  localparam int unsigned EXP_W    = 4;
  localparam int unsigned WIN_EXP  = 4;
  localparam int unsigned SCORE_W  = 5;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          ScoreMax = (1 << SCORE_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic                  move_valid = 1'b0;
  logic [1:0]            move_dir = 2'd0;
  logic                  move_ready, win, lose, busy;
  logic [NN*EXP_W-1:0]   grid;
  logic [SCORE_W-1:0]    score;

  always #5 clk = ~clk;

  game2048_engine #(
    .N         (N),
    .EXP_W     (EXP_W),
    .WIN_EXP   (WIN_EXP),
    .SCORE_W   (SCORE_W),
    .LFSR_SEED (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .grid       (grid),
    .score      (score),
    .win        (win),
    .lose       (lose),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Game model state.
  int   mb[NN];
  int   mscore;
  bit   mwin, mlose;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] step_n(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) v = step(v);
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= step(m_lfsr);
  end

  function automatic void model_clear();
    for (int i = 0; i < NN; i++) mb[i] = 0;
    mscore = 0;
    mwin   = 1'b0;
    mlose  = 1'b0;
  endfunction

  // Scan from lfsr mod NN for an empty cell; returns cycles spent.
  function automatic int model_spawn(input logic [15:0] l);
    int p, j;
    p = int'(l % 16'(NN));
    j = 0;
    while (mb[p] != 0 && j < NN) begin
      p = (p + 1) % NN;
      l = step(l);
      j++;
    end
    mb[p] = (l[3:0] == 4'd0) ? 2 : 1;
    return j + 1;
  endfunction

  function automatic bit model_slide(input int dir);
    bit changed;
    int idx[N];
    int vals[$];
    int merged[$];
    int i;
    changed = 1'b0;
    for (int line = 0; line < N; line++) begin
      vals.delete();
      merged.delete();
      for (int k = 0; k < N; k++) begin
        case (dir)
          0:       idx[k] = line * N + k;
          1:       idx[k] = line * N + (N - 1 - k);
          2:       idx[k] = k * N + line;
          default: idx[k] = (N - 1 - k) * N + line;
        endcase
        if (mb[idx[k]] != 0) vals.push_back(mb[idx[k]]);
      end
      i = 0;
      while (i < vals.size()) begin
        if (i + 1 < vals.size() && vals[i] == vals[i+1]) begin
          merged.push_back(vals[i] + 1);
          mscore += 1 << (vals[i] + 1);
          if (mscore > ScoreMax) mscore = ScoreMax;
          i += 2;
        end else begin
          merged.push_back(vals[i]);
          i++;
        end
      end
      while (merged.size() < N) merged.push_back(0);
      for (int k = 0; k < N; k++) begin
        if (mb[idx[k]] != merged[k]) changed = 1'b1;
        mb[idx[k]] = merged[k];
      end
    end
    return changed;
  endfunction

  function automatic void model_check();
    bit big, empty, pair;
    int v;
    big = 0; empty = 0; pair = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        v = mb[r*N+c];
        if (v >= WIN_EXP) big = 1;
        if (v == 0) empty = 1;
        if (c + 1 < N) begin
          if (v == mb[r*N+c+1]) pair = 1;
        end
        if (r + 1 < N) begin
          if (v == mb[(r+1)*N+c]) pair = 1;
        end
      end
    end
    if (big) mwin = 1'b1;
    else if (!empty && !pair) mlose = 1'b1;
  endfunction

  task automatic compare_all(input string tag);
    logic [63:0] g;
    g = '0;
    for (int i = 0; i < NN; i++) g[i*EXP_W +: EXP_W] = EXP_W'(mb[i]);
    check({tag, "_grid"},  64'(grid),       g);
    check({tag, "_score"}, 64'(score),      64'(mscore));
    check({tag, "_win"},   64'(win),        64'(mwin));
    check({tag, "_lose"},  64'(lose),       64'(mlose));
    check({tag, "_ready"}, 64'(move_ready), 64'(!(mwin || mlose)));
    check({tag, "_busy"},  64'(busy),       64'(0));
  endtask

  task automatic wait_idle(input int from, output int cnt);
    cnt = from;
    while (busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic do_start(input bit with_move);
    logic [15:0] l;
    int k1, k2, cnt;
    start      = 1'b1;
    move_valid = with_move;
    move_dir   = 2'($urandom_range(0, 3));
    l          = m_lfsr;
    @(negedge clk);
    start      = 1'b0;
    move_valid = 1'b0;
    model_clear();
    k1 = model_spawn(step_n(l, 2));
    k2 = model_spawn(step_n(l, 2 + k1));
    wait_idle(0, cnt);
    check("start_latency", 64'(cnt), 64'(1 + k1 + k2));
    compare_all("start");
  endtask

  task automatic do_move(input int dir, input bit poke_start);
    logic [15:0] l;
    int k, cnt, exp_lat;
    bit changed;
    check("ready_before_move", 64'(move_ready), 64'(1));
    move_valid = 1'b1;
    move_dir   = 2'(dir);
    l          = m_lfsr;
    @(negedge clk);
    move_valid = 1'b0;
    start      = poke_start;  // must be ignored while sliding
    @(negedge clk);
    start      = 1'b0;
    changed = model_slide(dir);
    if (changed) begin
      k = model_spawn(step_n(l, N + 1));
      model_check();
      exp_lat = N + k + 1;
    end else begin
      exp_lat = N + 1;
    end
    wait_idle(1, cnt);
    check(changed ? "move_latency" : "noop_latency", 64'(cnt), 64'(exp_lat));
    compare_all(changed ? "move" : "noop");
  endtask

  task automatic do_reset_mid(input int dir);
    move_valid = 1'b1;
    move_dir   = 2'(dir);
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    check("mid_rst_grid",  64'(grid),       64'(0));
    check("mid_rst_score", 64'(score),      64'(0));
    check("mid_rst_win",   64'(win),        64'(0));
    check("mid_rst_lose",  64'(lose),       64'(0));
    check("mid_rst_ready", 64'(move_ready), 64'(0));
    check("mid_rst_busy",  64'(busy),       64'(0));
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_grid",  64'(grid),       64'(0));
    check("rst_score", 64'(score),      64'(0));
    check("rst_win",   64'(win),        64'(0));
    check("rst_lose",  64'(lose),       64'(0));
    check("rst_ready", 64'(move_ready), 64'(0));
    check("rst_busy",  64'(busy),       64'(0));
    reset = 1'b1;
    @(negedge clk);

    move_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_move_busy",  64'(busy),       64'(0));
    check("idle_move_ready", 64'(move_ready), 64'(0));
    move_valid = 1'b0;

    for (int g = 0; g < 14; g++) begin
      do_start(1'($urandom_range(0, 1)));
      for (int m = 0; m < 150 && !mwin && !mlose; m++) begin
        if (g == 2 && m == 4) begin
          do_reset_mid($urandom_range(0, 3));
          do_start(1'b0);
        end else if (g % 4 == 1 && m == 30) begin
          do_start(1'b1);
        end else begin
          do_move($urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
